// File: rtl/alu_op_sequencer_if.sv
// Command, ALU-decoder and result signal bundle for alu_op_sequencer.
// Purely combinational wiring with no latency of its own.
// Flow control is valid/ready on both the command side and the result side.
interface alu_op_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [1:0] cmd_op;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [1:0] alu_s;
  logic [3:0] alu_y0;
  logic [3:0] alu_y1;
  logic [3:0] alu_y2;
  logic [3:0] alu_y3;
  logic       alu_cout;
  logic       alu_sign;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_y;
  logic       res_flag;
  logic [1:0] res_op;
  logic       busy;

  // Environment side: issues commands, models the decoder, consumes results.
  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op,
    output alu_y0, alu_y1, alu_y2, alu_y3, alu_cout, alu_sign,
    output res_ready,
    input  cmd_ready, alu_a, alu_b, alu_s,
    input  res_valid, res_y, res_flag, res_op, busy
  );

  // Sequencer side.
  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op,
    input  alu_y0, alu_y1, alu_y2, alu_y3, alu_cout, alu_sign,
    input  res_ready,
    output cmd_ready, alu_a, alu_b, alu_s,
    output res_valid, res_y, res_flag, res_op, busy
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Generic synchronous FIFO with registered pointers and an occupancy counter.
// Read data is combinational from the head entry; a write is visible one edge later.
// push is ignored while full and pop is ignored while empty; push+pop keeps the count.
module fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdat,
  input  logic             pop,
  output logic [WIDTH-1:0] rdat,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      cnt;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdat    = mem[rptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop_ok)  rptr <= rptr + AW'(1);
      cnt <= cnt + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  // Storage needs no reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= wdat;
  end
endmodule

// Command sequencer for the 4-bit ALU decoder: queue {a,b,op}, drive, settle, capture.
// Push into an idle empty block at edge N: alu_* load at N+1, res_valid high after N+1+SETTLE.
// cmd_ready drops when the queue is full; a held result stalls issue until res_ready.
module alu_op_sequencer #(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst,
  alu_op_sequencer_if.slave  bus
);
  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
  } cmd_t;

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_HOLD} state_t;

  state_t     state;
  state_t     nxt;
  logic [3:0] cnt;
  cmd_t       wcmd;
  cmd_t       head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       pop;
  logic       capture;
  logic       release_res;
  logic [3:0] sel_y;
  logic       sel_flag;

  assign wcmd = '{a: bus.cmd_a, b: bus.cmd_b, op: bus.cmd_op};

  fifo #(.WIDTH($bits(cmd_t)), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.cmd_valid),
    .wdat  (wcmd),
    .pop   (pop),
    .rdat  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.cmd_ready = !fifo_full;
  assign bus.busy      = (state != ST_IDLE) || !fifo_empty;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= nxt;
  end

  // Next state: a released result chains straight into the next command.
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:   if (!fifo_empty) nxt = ST_SETTLE;
      ST_SETTLE: if (capture) nxt = ST_HOLD;
      ST_HOLD:   if (bus.res_ready) nxt = fifo_empty ? ST_IDLE : ST_SETTLE;
      default:   nxt = ST_IDLE;
    endcase
  end

  // Control strobes derived from the current state.
  always_comb begin
    pop         = 1'b0;
    capture     = 1'b0;
    release_res = 1'b0;
    case (state)
      ST_IDLE:   pop = !fifo_empty;
      ST_SETTLE: capture = (cnt == 4'(SETTLE - 1));
      ST_HOLD: begin
        release_res = bus.res_ready;
        pop         = bus.res_ready && !fifo_empty;
      end
      default: ;
    endcase
  end

  // Select the decoder output and flag matching the issued op.
  always_comb begin
    sel_y    = bus.alu_y0;
    sel_flag = 1'b0;
    case (bus.alu_s)
      2'b00: begin sel_y = bus.alu_y0; sel_flag = bus.alu_cout; end
      2'b01: begin sel_y = bus.alu_y1; sel_flag = bus.alu_sign; end
      2'b10: sel_y = bus.alu_y2;
      default: sel_y = bus.alu_y3;
    endcase
  end

  // Issue registers, settle counter and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.alu_a     <= '0;
      bus.alu_b     <= '0;
      bus.alu_s     <= '0;
      cnt           <= '0;
      bus.res_valid <= 1'b0;
      bus.res_y     <= '0;
      bus.res_flag  <= 1'b0;
      bus.res_op    <= '0;
    end else begin
      if (pop) begin
        bus.alu_a <= head.a;
        bus.alu_b <= head.b;
        bus.alu_s <= head.op;
        cnt       <= '0;
      end else if (state == ST_SETTLE) begin
        cnt <= cnt + 4'd1;
      end
      if (capture) begin
        bus.res_y     <= sel_y;
        bus.res_flag  <= sel_flag;
        bus.res_op    <= bus.alu_s;
        bus.res_valid <= 1'b1;
      end else if (release_res) begin
        bus.res_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural stand-in for the ALU decoder.
// Two instances: SETTLE=1 for function/ordering, SETTLE=3 for settle latency and reset.
// Inputs change on the falling edge and outputs are sampled there as well.
module tb_alu_op_sequencer;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  alu_op_sequencer_if b1 ();
  alu_op_sequencer_if b3 ();

  alu_op_sequencer #(.DEPTH(4), .SETTLE(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
  alu_op_sequencer #(.DEPTH(4), .SETTLE(3)) dut3 (.clk(clk), .rst(rst), .bus(b3.slave));

  // Decoder stand-in: sum, difference, compare flags, AND as op3.
  logic [4:0] sum1;
  logic [4:0] sum3;
  assign sum1        = {1'b0, b1.alu_a} + {1'b0, b1.alu_b};
  assign b1.alu_y0   = sum1[3:0];
  assign b1.alu_cout = sum1[4];
  assign b1.alu_y1   = b1.alu_a - b1.alu_b;
  assign b1.alu_y2   = {1'b0, b1.alu_a > b1.alu_b, b1.alu_a < b1.alu_b, b1.alu_a == b1.alu_b};
  assign b1.alu_y3   = b1.alu_a & b1.alu_b;
  assign b1.alu_sign = b1.alu_a < b1.alu_b;
  assign sum3        = {1'b0, b3.alu_a} + {1'b0, b3.alu_b};
  assign b3.alu_y0   = sum3[3:0];
  assign b3.alu_cout = sum3[4];
  assign b3.alu_y1   = b3.alu_a - b3.alu_b;
  assign b3.alu_y2   = {1'b0, b3.alu_a > b3.alu_b, b3.alu_a < b3.alu_b, b3.alu_a == b3.alu_b};
  assign b3.alu_y3   = b3.alu_a & b3.alu_b;
  assign b3.alu_sign = b3.alu_a < b3.alu_b;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no completion, required finish before 100000");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push1(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic [1:0] op);
    int n;
    n = 0;
    b1.cmd_a = a; b1.cmd_b = b; b1.cmd_op = op; b1.cmd_valid = 1'b1;
    while (b1.cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_accept"}, 8'(n < 50), 8'd1);
    @(negedge clk);
    b1.cmd_valid = 1'b0;
  endtask

  task automatic get1(input string tag, input logic [3:0] ey, input logic ef,
                      input logic [1:0] eop);
    int n;
    n = 0;
    while (b1.res_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 8'(b1.res_valid), 8'd1);
    chk({tag, "_y"}, 8'(b1.res_y), 8'(ey));
    chk({tag, "_flag"}, 8'(b1.res_flag), 8'(ef));
    chk({tag, "_op"}, 8'(b1.res_op), 8'(eop));
    b1.res_ready = 1'b1;
    @(negedge clk);
    b1.res_ready = 1'b0;
  endtask

  initial begin
    logic [3:0] ta [6];
    logic [3:0] tb [6];
    logic [1:0] top [6];
    logic [3:0] tey [5];
    logic       tef [5];
    logic [3:0] wy [12];
    logic       wf [12];
    logic [3:0] da [6];
    logic [3:0] db [6];
    logic [1:0] dop [6];
    logic [3:0] dy [5];
    logic       df [5];
    logic       took;
    logic       seen;
    int         acc;
    int         n;

    ta  = '{4'hF, 4'h2, 4'h8, 4'hC, 4'h4, 4'h1};
    tb  = '{4'h1, 4'h5, 4'h3, 4'hA, 4'h4, 4'h1};
    top = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd0};
    tey = '{4'h0, 4'hD, 4'h4, 4'h8, 4'h1};
    tef = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    wy  = '{4'h2, 4'h4, 4'h6, 4'h8, 4'hA, 4'hC, 4'hE, 4'h0, 4'h2, 4'h4, 4'h6, 4'h8};
    wf  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    // B..G of the simultaneous push/pop scenario (A is handled separately).
    da  = '{4'h3, 4'h5, 4'hE, 4'hF, 4'h9, 4'h0};
    db  = '{4'h6, 4'h5, 4'h7, 4'hF, 4'h8, 4'h0};
    dop = '{2'd1, 2'd0, 2'd2, 2'd3, 2'd0, 2'd0};
    dy  = '{4'hD, 4'hA, 4'h4, 4'hF, 4'h1};
    df  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    rst = 1'b1;
    b1.cmd_valid = 1'b0; b1.cmd_a = '0; b1.cmd_b = '0; b1.cmd_op = '0; b1.res_ready = 1'b0;
    b3.cmd_valid = 1'b0; b3.cmd_a = '0; b3.cmd_b = '0; b3.cmd_op = '0; b3.res_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state.
    chk("rst_cmd_ready", 8'(b1.cmd_ready), 8'd1);
    chk("rst_alu_ab", {b1.alu_a, b1.alu_b}, 8'h00);
    chk("rst_res", {b1.res_valid, b1.res_flag, b1.res_op, b1.res_y}, 8'h00);
    chk("rst_s_busy", 8'({b1.alu_s, b1.busy}), 8'h00);
    rst = 1'b0;
    @(negedge clk);

    // First-command latency and add result.
    b1.cmd_a = 4'h7; b1.cmd_b = 4'hE; b1.cmd_op = 2'd0; b1.cmd_valid = 1'b1;
    @(negedge clk);
    b1.cmd_valid = 1'b0;
    chk("t1_valid_n0", 8'(b1.res_valid), 8'd0);
    chk("t1_busy", 8'(b1.busy), 8'd1);
    @(negedge clk);
    chk("t1_valid_n1", 8'(b1.res_valid), 8'd0);
    chk("t1_alu_ab", {b1.alu_a, b1.alu_b}, 8'h7E);
    chk("t1_alu_s", 8'(b1.alu_s), 8'd0);
    @(negedge clk);
    chk("t1_valid_n2", 8'(b1.res_valid), 8'd1);
    chk("t1_y", 8'(b1.res_y), 8'h05);
    chk("t1_flag", 8'(b1.res_flag), 8'd1);
    chk("t1_op", 8'(b1.res_op), 8'd0);
    b1.res_ready = 1'b1;
    @(negedge clk);
    b1.res_ready = 1'b0;
    chk("t1_valid_clr", 8'(b1.res_valid), 8'd0);
    chk("t1_idle", 8'(b1.busy), 8'd0);

    // Compare, subtract and op3 on the same operands.
    push1("t2_cmp", 4'h7, 4'hE, 2'd2);
    get1("t2_cmp", 4'b0010, 1'b0, 2'd2);
    push1("t2_sub", 4'h7, 4'hE, 2'd1);
    get1("t2_sub", 4'b1001, 1'b1, 2'd1);
    push1("t2_op3", 4'h7, 4'hE, 2'd3);
    get1("t2_op3", 4'b0110, 1'b0, 2'd3);

    // Result and issue registers frozen while res_ready is low.
    push1("t4", 4'h9, 4'h9, 2'd0);
    n = 0;
    while (b1.res_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      chk("t4_res", {b1.res_valid, b1.res_flag, b1.res_op, b1.res_y}, 8'hC2);
      chk("t4_alu_ab", {b1.alu_a, b1.alu_b}, 8'h99);
      chk("t4_alu_s", 8'(b1.alu_s), 8'd0);
      @(negedge clk);
    end
    get1("t4_rel", 4'h2, 1'b1, 2'd0);

    // Capacity: one in flight plus four queued.
    acc = 0;
    b1.cmd_a = ta[0]; b1.cmd_b = tb[0]; b1.cmd_op = top[0]; b1.cmd_valid = 1'b1;
    repeat (20) begin
      took = b1.cmd_ready;
      @(negedge clk);
      if (took) begin
        acc++;
        if (acc < 6) begin
          b1.cmd_a = ta[acc]; b1.cmd_b = tb[acc]; b1.cmd_op = top[acc];
        end
      end
    end
    chk("t3_accepted", 8'(acc), 8'd5);
    chk("t3_cmd_ready", 8'(b1.cmd_ready), 8'd0);
    chk("t3_busy", 8'(b1.busy), 8'd1);
    b1.cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) get1($sformatf("t3_res%0d", i), tey[i], tef[i], top[i]);
    chk("t3_drained", {b1.busy, b1.res_valid, b1.cmd_ready}, 8'h01);

    // Simultaneous push and pop with two queued entries.
    push1("t6_a", 4'h1, 4'h2, 2'd0);
    push1("t6_b", da[0], db[0], dop[0]);
    push1("t6_c", da[1], db[1], dop[1]);
    n = 0;
    while (b1.res_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t6_a_res", {b1.res_valid, b1.res_flag, b1.res_op, b1.res_y}, 8'h83);
    chk("t6_ready_at2", 8'(b1.cmd_ready), 8'd1);
    b1.res_ready = 1'b1;
    b1.cmd_a = da[2]; b1.cmd_b = db[2]; b1.cmd_op = dop[2]; b1.cmd_valid = 1'b1;
    @(negedge clk);
    b1.res_ready = 1'b0;
    b1.cmd_a = da[3]; b1.cmd_b = db[3]; b1.cmd_op = dop[3];
    acc = 3;
    repeat (20) begin
      took = b1.cmd_ready;
      @(negedge clk);
      if (took) begin
        acc++;
        if (acc < 6) begin
          b1.cmd_a = da[acc]; b1.cmd_b = db[acc]; b1.cmd_op = dop[acc];
        end
      end
    end
    chk("t6_extra_accepted", 8'(acc - 3), 8'd2);
    chk("t6_full", 8'(b1.cmd_ready), 8'd0);
    b1.cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) get1($sformatf("t6_res%0d", i), dy[i], df[i], dop[i]);

    // Pointer wrap: three fill/drain rounds of four commands.
    for (int c = 0; c < 3; c++) begin
      for (int j = 0; j < 4; j++)
        push1($sformatf("wrap_push%0d", c * 4 + j), 4'(c * 4 + j + 1), 4'(c * 4 + j + 1), 2'd0);
      for (int j = 0; j < 4; j++)
        get1($sformatf("wrap_res%0d", c * 4 + j), wy[c * 4 + j], wf[c * 4 + j], 2'd0);
    end

    // SETTLE=3 latency.
    b3.cmd_a = 4'h7; b3.cmd_b = 4'hE; b3.cmd_op = 2'd0; b3.cmd_valid = 1'b1;
    @(negedge clk);
    b3.cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("s3_valid_n%0d", i), 8'(b3.res_valid), 8'd0);
      @(negedge clk);
    end
    chk("s3_valid_n4", 8'(b3.res_valid), 8'd1);
    chk("s3_res", {b3.res_flag, b3.res_op, b3.res_y}, 8'h45);
    b3.res_ready = 1'b1;
    @(negedge clk);
    b3.res_ready = 1'b0;

    // Reset in the middle of the settle window.
    b3.cmd_a = 4'h3; b3.cmd_b = 4'h4; b3.cmd_op = 2'd0; b3.cmd_valid = 1'b1;
    @(negedge clk);
    b3.cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("s3_pre_rst", {b3.busy, b3.res_valid, 2'b00, b3.alu_a}, 8'h83);
    rst = 1'b1;
    #1;
    chk("s3_rst_alu_ab", {b3.alu_a, b3.alu_b}, 8'h00);
    chk("s3_rst_res", {b3.res_valid, b3.res_flag, b3.res_op, b3.res_y}, 8'h00);
    chk("s3_rst_ctl", 8'({b3.alu_s, b3.busy, b3.cmd_ready}), 8'h01);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen = seen | b3.res_valid;
    end
    chk("s3_no_result", 8'(seen), 8'd0);
    chk("s3_idle", 8'(b3.busy), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
